// File: rtl/pipeline_run_ctrl.sv
// Execution controller for the MIPS pipeline: it gates the pipeline's valid input for
// free-running, stepped or stopped execution, and drains in-flight instructions after a halt.
module pipeline_run_ctrl #(
    parameter int          NB_INSTR     = 32,
    parameter int          NB_CYCLE_CNT = 32,
    parameter int          NB_STEP      = 16,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    input  logic [1:0]              i_cmd,
    input  logic [NB_STEP-1:0]      i_step_count,
    output logic                    o_cmd_ready,
    input  logic [NB_INSTR-1:0]     i_instr,
    output logic                    o_pipe_valid,
    output logic                    o_fetch_hold,
    output logic [2:0]              o_state,
    output logic [NB_CYCLE_CNT-1:0] o_cycle_count,
    output logic                    o_halted,
    output logic                    o_done
);

    localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES);

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [NB_STEP-1:0]      rem_r, rem_s;
    logic [NB_DRAIN-1:0]     drain_r, drain_s;
    logic [NB_CYCLE_CNT-1:0] cnt_r;
    logic                    valid_r, hold_r, halted_r, done_r;
    logic                    done_s, clr_s, acc_s, halt_seen_s;

    assign o_cmd_ready   = (state_r != S_DRAIN);
    assign o_state       = state_r;
    assign o_pipe_valid  = valid_r;
    assign o_fetch_hold  = hold_r;
    assign o_cycle_count = cnt_r;
    assign o_halted      = halted_r;
    assign o_done        = done_r;

    assign acc_s = i_cmd_valid & o_cmd_ready;
    // Only a freshly fetched instruction can halt; held fetch slots are drain bubbles.
    assign halt_seen_s = valid_r & ~hold_r & (i_instr == NB_INSTR'(HALT_INSTR));

    // Next-state logic; halt outranks STOP, which outranks step exhaustion.
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        drain_s = drain_r;
        done_s  = 1'b0;
        clr_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (acc_s) begin
                    case (i_cmd)
                        CMD_RUN:   state_s = S_RUN;
                        CMD_STEP: begin
                            state_s = S_STEP;
                            rem_s   = (i_step_count == '0) ? NB_STEP'(1) : i_step_count;
                        end
                        CMD_CLEAR: clr_s = 1'b1;
                        default:   state_s = S_IDLE;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (halt_seen_s) begin
                    state_s = S_DRAIN;
                    drain_s = DRAIN_LOAD;
                end else if (acc_s && (i_cmd == CMD_STOP)) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_STEP: begin
                if (halt_seen_s) begin
                    state_s = S_DRAIN;
                    drain_s = DRAIN_LOAD;
                end else if (acc_s && (i_cmd == CMD_STOP)) begin
                    state_s = S_IDLE;
                end else if (rem_r <= NB_STEP'(1)) begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                end else begin
                    rem_s = rem_r - NB_STEP'(1);
                end
            end
            S_DRAIN: begin
                if (drain_r <= NB_DRAIN'(1)) begin
                    state_s = S_HALTED;
                    done_s  = 1'b1;
                end else begin
                    drain_s = drain_r - NB_DRAIN'(1);
                end
            end
            S_HALTED: begin
                if (acc_s && (i_cmd == CMD_CLEAR)) begin
                    state_s = S_IDLE;
                    clr_s   = 1'b1;
                end else begin
                    state_s = S_HALTED;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, registered outputs and the saturating enabled-cycle counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r  <= S_IDLE;
            rem_r    <= '0;
            drain_r  <= '0;
            valid_r  <= 1'b0;
            hold_r   <= 1'b0;
            halted_r <= 1'b0;
            done_r   <= 1'b0;
            cnt_r    <= '0;
        end else begin
            state_r  <= state_s;
            rem_r    <= rem_s;
            drain_r  <= drain_s;
            valid_r  <= (state_s == S_RUN) || (state_s == S_STEP) || (state_s == S_DRAIN);
            hold_r   <= (state_s == S_DRAIN);
            halted_r <= (state_s == S_HALTED);
            done_r   <= done_s;
            if (clr_s) begin
                cnt_r <= '0;
            end else if (valid_r && (cnt_r != '1)) begin
                cnt_r <= cnt_r + NB_CYCLE_CNT'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed scenarios plus random commands, checked every cycle
// against a mode/counter model of the controller (second instance has a 4-bit counter).
module tb_pipeline_run_ctrl;

    localparam int          D    = 4;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [1:0]  RUN = 2'd0, STEP = 2'd1, STOP = 2'd2, CLEAR = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [15:0] step_count = 16'd0;
    logic [31:0] instr = 32'd0;

    logic        cmd_ready, pipe_valid, fetch_hold, halted, done;
    logic [2:0]  state;
    logic [31:0] cycle_count;
    logic        cmd_ready_b, pipe_valid_b, fetch_hold_b, halted_b, done_b;
    logic [2:0]  state_b;
    logic [3:0]  cycle_count_b;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    // behavioural model: free-run flag, remaining steps, remaining drain cycles
    bit     m_run, m_halted, m_done;
    int     m_steps, m_drain;
    longint m_cnt, m_cnt_b;

    always #5 clk = ~clk;

    pipeline_run_ctrl #(.DRAIN_CYCLES(D)) dut (
        .i_clock(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_count(step_count), .o_cmd_ready(cmd_ready), .i_instr(instr),
        .o_pipe_valid(pipe_valid), .o_fetch_hold(fetch_hold), .o_state(state),
        .o_cycle_count(cycle_count), .o_halted(halted), .o_done(done)
    );

    pipeline_run_ctrl #(.NB_CYCLE_CNT(4), .DRAIN_CYCLES(D)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_count(step_count), .o_cmd_ready(cmd_ready_b), .i_instr(instr),
        .o_pipe_valid(pipe_valid_b), .o_fetch_hold(fetch_hold_b), .o_state(state_b),
        .o_cycle_count(cycle_count_b), .o_halted(halted_b), .o_done(done_b)
    );

    function automatic bit m_valid();
        return m_run || (m_steps > 0) || (m_drain > 0);
    endfunction

    function automatic int m_state();
        if (m_drain > 0) return 3;
        if (m_halted)    return 4;
        if (m_run)       return 1;
        if (m_steps > 0) return 2;
        return 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs the DUT also sees.
    always @(posedge clk) begin : model
        bit mv, hs, acc, dn;
        mv = m_valid();
        if (rst) begin
            m_run = 0; m_halted = 0; m_done = 0; m_steps = 0; m_drain = 0;
            m_cnt = 0; m_cnt_b = 0;
        end else begin
            hs  = mv && (m_drain == 0) && (instr == HALT);
            acc = cmd_valid && (m_drain == 0);
            dn  = 0;
            if (mv) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt_b < 15) m_cnt_b++;
            end
            if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) begin m_halted = 1; dn = 1; end
            end else if (hs) begin
                m_run = 0; m_steps = 0; m_drain = D;
            end else if (m_halted) begin
                if (acc && cmd == CLEAR) begin m_halted = 0; m_cnt = 0; m_cnt_b = 0; end
            end else if (m_run) begin
                if (acc && cmd == STOP) m_run = 0;
            end else if (m_steps > 0) begin
                if (acc && cmd == STOP) m_steps = 0;
                else begin
                    m_steps--;
                    if (m_steps == 0) dn = 1;
                end
            end else if (acc) begin
                if (cmd == RUN) m_run = 1;
                else if (cmd == STEP) m_steps = (step_count == 0) ? 1 : int'(step_count);
                else if (cmd == CLEAR) begin m_cnt = 0; m_cnt_b = 0; end
            end
            m_done = dn;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pipe_valid", pipe_valid, m_valid());
            chk("fetch_hold", fetch_hold, m_drain > 0);
            chk("cmd_ready", cmd_ready, m_drain == 0);
            chk("state", state, m_state());
            chk("halted", halted, m_halted);
            chk("done", done, m_done);
            chk("cycle_count", cycle_count, m_cnt);
            chk("pipe_valid_b", pipe_valid_b, m_valid());
            chk("state_b", state_b, m_state());
            chk("cycle_count_b", cycle_count_b, m_cnt_b);
        end
    end

    task automatic send(input logic [1:0] c, input logic [15:0] n);
        cmd_valid = 1'b1; cmd = c; step_count = n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic observe(input int n, output int v, output int d, output int h);
        v = 0; d = 0; h = 0;
        for (int i = 0; i < n; i++) begin
            v += int'(pipe_valid); d += int'(done); h += int'(fetch_hold);
            @(negedge clk);
        end
    endtask

    initial begin
        int v, d, h;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_valid", pipe_valid, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_count", cycle_count, 0);

        send(STEP, 16'd3);
        observe(6, v, d, h);
        chk("step3_valid_cycles", v, 3);
        chk("step3_done_pulses", d, 1);
        chk("step3_count", cycle_count, 3);
        chk("step3_state", state, 0);
        chk("model_step3_count", m_cnt, 3);

        send(STEP, 16'd0);
        observe(4, v, d, h);
        chk("step0_valid_cycles", v, 1);
        chk("step0_done_pulses", d, 1);
        chk("step0_count", cycle_count, 4);

        send(CLEAR, 16'd0);
        chk("clear_idle_count", cycle_count, 0);
        send(RUN, 16'd0);
        observe(9, v, d, h);
        send(STOP, 16'd0);
        v = v + 1;
        begin
            int v2, d2, h2;
            observe(3, v2, d2, h2);
            chk("run_stop_after_valid", v2, 0);
            d = d + d2;
        end
        chk("run_valid_cycles", v, 10);
        chk("run_no_done", d, 0);
        chk("run_count", cycle_count, 10);
        send(STEP, 16'd2);
        observe(4, v, d, h);
        chk("run_step2_count", cycle_count, 12);
        chk("model_run_step2_count", m_cnt, 12);

        send(CLEAR, 16'd0);
        send(RUN, 16'd0);
        repeat (4) @(negedge clk);
        instr = HALT;
        @(negedge clk);
        instr = 32'd0;
        for (int i = 0; i < D; i++) begin
            chk("drain_ready", cmd_ready, 0);
            chk("drain_hold", fetch_hold, 1);
            chk("drain_valid", pipe_valid, 1);
            @(negedge clk);
        end
        chk("halt_halted", halted, 1);
        chk("halt_done", done, 1);
        chk("halt_state", state, 4);
        chk("halt_valid", pipe_valid, 0);
        chk("halt_ready", cmd_ready, 1);
        chk("halt_count", cycle_count, 9);

        send(RUN, 16'd0);
        observe(3, v, d, h);
        chk("halted_run_ignored", v, 0);
        send(STEP, 16'd5);
        observe(3, v, d, h);
        chk("halted_step_ignored", v, 0);
        chk("halted_state_kept", state, 4);
        send(CLEAR, 16'd0);
        chk("clear_state", state, 0);
        chk("clear_count", cycle_count, 0);
        chk("clear_halted", halted, 0);

        send(RUN, 16'd0);
        repeat (19) @(negedge clk);
        send(STOP, 16'd0);
        @(negedge clk);
        chk("sat_count_b", cycle_count_b, 15);
        chk("sat_count_wide", cycle_count, 20);

        send(RUN, 16'd0);
        @(negedge clk);
        instr = HALT;
        @(negedge clk);
        instr = 32'd0;
        @(negedge clk);
        chk("middrain_state", state, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_drain_state", state, 0);
        chk("rst_drain_valid", pipe_valid, 0);
        chk("rst_drain_hold", fetch_hold, 0);
        chk("rst_drain_count", cycle_count, 0);
        chk("rst_drain_halted", halted, 0);
        chk("rst_drain_done", done, 0);
        chk("rst_drain_ready", cmd_ready, 1);

        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd        = 2'($urandom_range(0, 3));
            step_count = 16'($urandom_range(0, 6));
            instr      = ($urandom_range(0, 19) == 0) ? HALT : 32'($urandom);
            rst        = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
